// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between IFU and LSU, one transaction at a time (IDLE/ISSUE/WAIT/RESP).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IFU.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wmask,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [3:0]      wmask_q;
  logic [DW-1:0]   ifu_rdata_q;
  logic [DW-1:0]   lsu_rdata_q;
  logic            lsu_first_s;
  logic            grant_lsu_s;
  logic            grant_ifu_s;
  logic            accept_s;

`ifdef MEM_ARB_RR_EN
  logic            last_grant_q;

  // Remember who won the last grant so a contested cycle alternates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWNER_LSU;
    end else if (accept_s) begin
      last_grant_q <= grant_lsu_s ? OWNER_LSU : OWNER_IFU;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

  assign lsu_first_s = (last_grant_q == OWNER_IFU);
`else
  assign lsu_first_s = 1'b1;
`endif

  // Grant decision; only meaningful in IDLE.
  always_comb begin
    grant_lsu_s = lsu_req_valid && (!ifu_req_valid || lsu_first_s);
    grant_ifu_s = ifu_req_valid && !grant_lsu_s;
    accept_s    = (state_q == S_IDLE) && !rst && (grant_lsu_s || grant_ifu_s);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completions outside WAIT are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept_s ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = mem_req_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  state_d = mem_resp_valid ? S_RESP : S_WAIT;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        ifu_req_ready = accept_s && grant_ifu_s;
        lsu_req_ready = accept_s && grant_lsu_s;
      end
      S_ISSUE: mem_req_valid = 1'b1;
      S_WAIT:  mem_req_valid = 1'b0;
      S_RESP: begin
        ifu_resp_valid = (owner_q == OWNER_IFU);
        lsu_resp_valid = (owner_q == OWNER_LSU);
      end
      default: busy = 1'b1;
    endcase
  end

  // Request payload captured at accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWNER_IFU;
      addr_q  <= {AW{1'b0}};
      wen_q   <= 1'b0;
      wdata_q <= {DW{1'b0}};
      wmask_q <= 4'b0000;
    end else if (accept_s && grant_lsu_s) begin
      owner_q <= OWNER_LSU;
      addr_q  <= lsu_addr;
      wen_q   <= lsu_wen;
      wdata_q <= lsu_wdata;
      wmask_q <= lsu_wen ? lsu_wmask : 4'b0000;
    end else if (accept_s) begin
      owner_q <= OWNER_IFU;
      addr_q  <= ifu_addr;
      wen_q   <= 1'b0;
      wdata_q <= {DW{1'b0}};
      wmask_q <= 4'b0000;
    end else begin
      owner_q <= owner_q;
      addr_q  <= addr_q;
      wen_q   <= wen_q;
      wdata_q <= wdata_q;
      wmask_q <= wmask_q;
    end
  end

  // Per-requester read data; writes return zero, the other requester's value is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rdata_q <= {DW{1'b0}};
      lsu_rdata_q <= {DW{1'b0}};
    end else if ((state_q == S_WAIT) && mem_resp_valid && (owner_q == OWNER_LSU)) begin
      lsu_rdata_q <= wen_q ? {DW{1'b0}} : mem_rdata;
    end else if ((state_q == S_WAIT) && mem_resp_valid) begin
      ifu_rdata_q <= mem_rdata;
    end else begin
      ifu_rdata_q <= ifu_rdata_q;
      lsu_rdata_q <= lsu_rdata_q;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single physical memory port (DPI pmem read/write path) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Moves the core from a combinational fetch to a multi-cycle, handshake-based memory access.
- Serialises one outstanding transaction at a time: request phase, memory wait, response phase.
- Sits between the IFU/LSU and the memory bridge module that calls v_pmem_read/v_pmem_write.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  IFU read address
- ifu_resp_valid  out  1  one-cycle pulse, IFU read data valid
- ifu_rdata  out  DW  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DW  write data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  one-cycle pulse, LSU read data / write ack
- lsu_rdata  out  DW  LSU read data (0 for writes)
- mem_req_valid  out  1  request to memory bridge
- mem_req_ready  in  1  memory bridge accepts request
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write enable (0 for IFU)
- mem_wdata  out  DW  latched write data
- mem_wmask  out  4  latched mask (0 for IFU or reads)
- mem_resp_valid  in  1  memory completion (read data or write ack)
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (async, rst=1):
  - state=IDLE; all *_ready, *_resp_valid and mem_req_valid = 0.
  - All data outputs = 0; owner register = IFU; busy = 0.
- IDLE:
  - Grant is computed combinationally from the valids; only the granted requester sees ready=1.
  - Default policy is fixed priority, LSU over IFU.
  - A request is accepted when valid&&ready. On accept, latch addr/wen/wdata/wmask and owner, then go to ISSUE.
  - IFU requests latch wen=0 and wmask=0.
  - No valid: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched payload held stable.
  - On mem_req_ready=1, go to WAIT.
  - mem_resp_valid in this state is ignored.
- WAIT:
  - On mem_resp_valid=1, latch mem_rdata (latch 0 if the transaction is a write), then go to RESP.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle, rdata = latched value; then go to IDLE.
  - The non-owner's resp_valid stays 0.
- Both *_req_ready are 0 in every state except IDLE. Back-to-back: a new request is accepted at the earliest in the cycle after RESP.
- Minimum latency, with mem_req_ready=1 in ISSUE and mem_resp_valid one cycle later:
  - accept at cycle 0, ISSUE at 1, WAIT at 2, RESP at 3.
  - So resp_valid arrives 3 cycles after the accept.
- *_rdata holds its last value until the next response to that requester.
- mem_resp_valid in IDLE or RESP (a stray or pre-reset completion) is ignored with no state change.
- Reset mid-transaction aborts immediately: no response is delivered, and a late mem_resp_valid after reset falls in IDLE and is ignored.
- Requester inputs are sampled only at accept; changes afterwards have no effect.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin policy.
  - When both request in IDLE, grant the requester not granted last.
  - The last-grant register resets to LSU, so IFU wins the first contested cycle.
  - A single requester is always granted.
- Not defined: fixed LSU-over-IFU priority, and no last-grant register is synthesised.

Test Plan:
- IFU only, ifu_addr=0x80000000, memory returns 0x00100073 one cycle after ready -> ifu_req_ready in cycle 0, mem_req_valid in cycle 1 with addr 0x80000000 and wen=0, ifu_resp_valid pulse in cycle 3 with rdata 0x00100073, lsu_resp_valid stays 0.
- LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011; bridge holds mem_req_ready=0 for 3 cycles -> mem_req_valid and payload stable for all 3 cycles, then one lsu_resp_valid pulse with lsu_rdata=0.
- Both valid in the same IDLE cycle, repeated 4 transactions -> fixed priority: LSU granted all 4 while it keeps requesting. With MEM_ARB_RR_EN: IFU, LSU, IFU, LSU.
- rst asserted asynchronously while in WAIT, then mem_resp_valid pulses after rst deasserts -> outputs 0 immediately, state IDLE, no resp_valid pulse, busy=0.
- mem_resp_valid pulsed in IDLE and during ISSUE -> ignored: no state change and no resp pulse.
- Back-to-back IFU requests with valid held high -> second ifu_req_ready asserts exactly in the cycle after the first RESP; busy low only in that IDLE cycle.
